// File: rtl/keynsham_ram_arbiter.sv
// Two-master arbiter for the keynsham RAM data port: one single-cycle RAM access per transaction.
// Define KEYNSHAM_RAM_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module keynsham_ram_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_access,
    input  logic        m0_cs,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_bytesel,
    input  logic [31:0] m0_wr_val,
    input  logic        m0_wr_en,
    output logic [31:0] m0_data,
    output logic        m0_ack,

    input  logic        m1_access,
    input  logic        m1_cs,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_bytesel,
    input  logic [31:0] m1_wr_val,
    input  logic        m1_wr_en,
    output logic [31:0] m1_data,
    output logic        m1_ack,

    output logic        ram_access,
    output logic        ram_cs,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_bytesel,
    output logic [31:0] ram_wr_val,
    output logic        ram_wr_en,
    input  logic [31:0] ram_data,
    input  logic        ram_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  bytesel;
        logic [31:0] wr_val;
        logic        wr_en;
    } req_t;

    state_t     state, state_nxt;
    req_t [1:0] req_in;
    req_t       req_q;
    logic [1:0] req;
    logic       grant_q;
    logic       grant_nxt;
    logic       done;

    always_comb begin
        req[0]    = m0_access & m0_cs;
        req[1]    = m1_access & m1_cs;
        req_in[0] = '{addr: m0_addr, bytesel: m0_bytesel, wr_val: m0_wr_val, wr_en: m0_wr_en};
        req_in[1] = '{addr: m1_addr, bytesel: m1_bytesel, wr_val: m1_wr_val, wr_en: m1_wr_en};
    end

`ifdef KEYNSHAM_RAM_ARB_RR_EN
    // last_q holds the index of the most recent grant; contention goes to the other master.
    logic last_q;

    always_comb begin
        if (req == 2'b11)
            grant_nxt = ~last_q;
        else
            grant_nxt = ~req[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= 1'b1;
        else if (state == IDLE && |req)
            last_q <= grant_nxt;
    end
`else
    // Master 1 wins only when master 0 is not requesting.
    assign grant_nxt = ~req[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (ram_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requests are captured only in IDLE, so a master still holding its request in the ack cycle is not re-issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            grant_q <= 1'b0;
        end else if (state == IDLE && |req) begin
            req_q   <= req_in[grant_nxt];
            grant_q <= grant_nxt;
        end
    end

    always_comb begin
        ram_access  = 1'b0;
        ram_cs      = 1'b0;
        ram_wr_en   = 1'b0;
        ram_addr    = req_q.addr;
        ram_bytesel = req_q.bytesel;
        ram_wr_val  = req_q.wr_val;
        done        = 1'b0;
        m0_ack      = 1'b0;
        m1_ack      = 1'b0;
        m0_data     = '0;
        m1_data     = '0;
        case (state)
            ISSUE: begin
                ram_access = 1'b1;
                ram_cs     = 1'b1;
                ram_wr_en  = req_q.wr_en;
            end
            WAIT: begin
                done = ram_ack;
            end
            default: ;
        endcase
        if (done) begin
            m0_ack  = ~grant_q;
            m1_ack  = grant_q;
            m0_data = grant_q ? 32'h0 : ram_data;
            m1_data = grant_q ? ram_data : 32'h0;
        end
    end

endmodule

// File: doc/keynsham_ram_arbiter.md
# keynsham_ram_arbiter

Two-master arbiter that shares the single data port of the keynsham on-chip RAM between the CPU data bus (master 0) and a second bus master (master 1, debug/DMA). It accepts one RAM transaction at a time and issues it to the RAM as exactly one single-cycle access. It then routes the RAM's one-cycle-later acknowledge and read data back to the granted master. The instruction port of the RAM is not touched by this block.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mN_access  in  1  master N (N = 0, 1) bus transaction valid; held until mN_ack.
- mN_cs  in  1  master N RAM chip select; request = mN_access & mN_cs.
- mN_addr  in  32  master N byte address; forwarded unchanged.
- mN_bytesel  in  4  master N byte enables.
- mN_wr_val  in  32  master N write data.
- mN_wr_en  in  1  master N write (1) / read (0).
- mN_data  out  32  read data to master N; ram_data when mN_ack, else 0.
- mN_ack  out  1  one-cycle completion pulse to master N.
- ram_access, ram_cs  out  1  RAM access strobe and select, asserted together.
- ram_addr  out  32, ram_bytesel out 4, ram_wr_val out 32, ram_wr_en out 1  registered copy of the winning request.
- ram_data  in  32  RAM read data, valid with ram_ack.
- ram_ack  in  1  RAM completion, one cycle after ram_access & ram_cs.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a winner and register its addr, bytesel, wr_val, wr_en and its grant index. Go to ISSUE.
- ISSUE: drive ram_access = ram_cs = 1 for exactly one cycle from the registered fields, then go to WAIT. ram_wr_en is 0 outside ISSUE, so each write happens exactly once.
- WAIT:
  - On ram_ack: assert m[grant]_ack = 1 and m[grant]_data = ram_data in the same cycle (combinational), then go to IDLE.
  - Without ram_ack: stay in WAIT. No timeout.
- The non-granted master sees ack = 0 and data = 0, and its request stays pending.
- ram_ack outside WAIT is ignored and never reaches a master.
- mN_access & !mN_cs is not a request and never produces an ack.
- Master rules:
  - Hold request fields stable from assertion until the ack cycle.
  - Drop the request, or present the next one, on the cycle after the ack.
  - The arbiter samples requests only in IDLE, so an ack cycle never double-counts a request.
- Default arbitration: fixed priority, master 0 wins whenever both request.

## Timing
- Reset values:
  - state = IDLE, grant index = 0, last-grant pointer = 1.
  - All ram_* outputs = 0.
  - m0_ack = m1_ack = 0, m0_data = m1_data = 0.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. An in-flight ram_ack after reset release is ignored. The aborted master receives no ack.
- Latency, request seen in IDLE at cycle 0: ram_access in cycle 1, mN_ack in cycle 2.
- Throughput: one transaction per 3 cycles.
- Back-to-back by the same master: new request at cycle 3, ack at cycle 5.
- Simultaneous requests: the loser is served next. Its ack arrives 3 cycles after the winner's ack.

## Configuration
- KEYNSHAM_RAM_ARB_RR_EN:
  - Defined: round-robin. On contention, the master not granted last wins. The last-grant pointer updates on each grant. Reset pointer = 1, so master 0 wins the first contention.
  - Undefined: fixed priority, master 0 always wins and the pointer logic is absent.
  - Uncontended behaviour is identical in both builds.

## Test plan
- Reset: hold rst, toggle clk, drive requests. All ram_* outputs and mN_ack/mN_data stay 0.
- m0 writes 0xDEADBEEF to 0x10 with bytesel 4'b1111, then reads 0x10.
  - Write: ram_wr_en = 1 for exactly one cycle, m0_ack in cycle 2.
  - Read: m0_data = 0xDEADBEEF with m0_ack in cycle 2.
- m1 byte write 0xAA with bytesel 4'b0010 to 0x20, then reads back. Bytes 0, 2 and 3 are unchanged and byte 1 = 0xAA. m0 sees no ack.
- Both masters request reads in the same cycle.
  - Without the macro: m0 is acked at cycle 2 and m1 at cycle 5.
  - With KEYNSHAM_RAM_ARB_RR_EN and both held continuously: acks alternate m0, m1, m0, m1, spaced 3 cycles apart.
- m0_access = 1 with m0_cs = 0 for 10 cycles. ram_access never asserts and m0_ack is never asserted.
- Assert rst in the WAIT cycle of an m1 read. No m1_ack. After release, a new m0 read completes normally in 2 cycles.
